// File: rtl/robo_ambiente.sv
// Environment model for the Robo controller: map, robot pose, sensors and debris removal.
// Optional STEP_MODE_EN adds step_mode/step_req to single-step the ACT phase.
module robo_ambiente #(
  parameter int ROWS        = 10,
  parameter int COLS        = 20,
  parameter int ROW_W       = 4,
  parameter int COL_W       = 5,
  parameter int LIFE_LEVE   = 3,
  parameter int LIFE_MEDIO  = 6,
  parameter int LIFE_PESADO = 9
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cfg_we,
  input  logic [ROW_W-1:0] cfg_row,
  input  logic [COL_W-1:0] cfg_col,
  input  logic [2:0]       cfg_cell,
  input  logic             start,
  input  logic [ROW_W-1:0] start_row,
  input  logic [COL_W-1:0] start_col,
  input  logic [1:0]       start_dir,
`ifdef STEP_MODE_EN
  input  logic             step_mode,
  input  logic             step_req,
`endif
  input  logic             avancar,
  input  logic             girar,
  input  logic             recolher_entulho,
  output logic             head,
  output logic             left,
  output logic             under,
  output logic             barrier,
  output logic             sens_valid,
  output logic [ROW_W-1:0] pos_row,
  output logic [COL_W-1:0] pos_col,
  output logic [1:0]       pos_dir,
  output logic [3:0]       life_cnt,
  output logic             anomaly
);
  localparam int CELLS = ROWS * COLS;
  localparam int IDX_W = $clog2(CELLS);
  localparam logic [ROW_W:0] ROWS_X  = (ROW_W+1)'(ROWS);
  localparam logic [COL_W:0] COLS_X  = (COL_W+1)'(COLS);
  localparam logic [ROW_W:0] ROW_ONE = (ROW_W+1)'(1);
  localparam logic [COL_W:0] COL_ONE = (COL_W+1)'(1);
  localparam logic [1:0] DIR_N = 2'b00, DIR_S = 2'b01, DIR_L = 2'b10, DIR_O = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_SENSE, S_ACT, S_ANOMALY} state_t;

  state_t           state_q, state_d;
  logic [ROW_W-1:0] pos_row_q, pos_row_d;
  logic [COL_W-1:0] pos_col_q, pos_col_d;
  logic [1:0]       pos_dir_q, pos_dir_d;
  logic [3:0]       life_q, life_d;
  logic             head_q, head_d, left_q, left_d, under_q, under_d, barrier_q, barrier_d;
  logic             sens_valid_q, sens_valid_d, anomaly_q, anomaly_d;

  logic [2:0]       map_q [CELLS];
  logic             map_we;
  logic [IDX_W-1:0] map_widx;
  logic [2:0]       map_wdata;

  logic [ROW_W:0]   row_x, fr_row, lf_row;
  logic [COL_W:0]   col_x, fr_col, lf_col;
  logic             cur_on, fr_on, lf_on, st_on, cfg_on, act_go;
  logic [2:0]       cur_v, fr_v, lf_v, st_v;
  logic [IDX_W-1:0] cur_idx, fr_idx, lf_idx, st_idx, cfg_idx;

  function automatic logic [IDX_W-1:0] cell_idx(input logic [ROW_W:0] r, input logic [COL_W:0] c);
    int lin;
    lin = int'(r) * COLS + int'(c);
    return IDX_W'(lin);
  endfunction

  function automatic logic [3:0] life_of(input logic [2:0] code);
    case (code)
      3'd3:    return 4'(LIFE_LEVE);
      3'd4:    return 4'(LIFE_MEDIO);
      default: return 4'(LIFE_PESADO);
    endcase
  endfunction

`ifdef STEP_MODE_EN
  assign act_go = !step_mode || step_req;
`else
  assign act_go = 1'b1;
`endif

  // Neighbour coordinates carry one spare bit so that "-1" wraps to a large unsigned off-map value.
  assign row_x = {1'b0, pos_row_q};
  assign col_x = {1'b0, pos_col_q};
  always_comb begin
    fr_row = row_x; fr_col = col_x; lf_row = row_x; lf_col = col_x;
    case (pos_dir_q)
      DIR_N:   begin fr_row = row_x - ROW_ONE; lf_col = col_x - COL_ONE; end
      DIR_S:   begin fr_row = row_x + ROW_ONE; lf_col = col_x + COL_ONE; end
      DIR_L:   begin fr_col = col_x + COL_ONE; lf_row = row_x - ROW_ONE; end
      default: begin fr_col = col_x - COL_ONE; lf_row = row_x + ROW_ONE; end
    endcase
  end

  assign cur_on  = (row_x < ROWS_X) && (col_x < COLS_X);
  assign fr_on   = (fr_row < ROWS_X) && (fr_col < COLS_X);
  assign lf_on   = (lf_row < ROWS_X) && (lf_col < COLS_X);
  assign st_on   = ({1'b0, start_row} < ROWS_X) && ({1'b0, start_col} < COLS_X);
  assign cfg_on  = ({1'b0, cfg_row} < ROWS_X) && ({1'b0, cfg_col} < COLS_X);
  assign cur_idx = cur_on ? cell_idx(row_x, col_x) : '0;
  assign fr_idx  = fr_on ? cell_idx(fr_row, fr_col) : '0;
  assign lf_idx  = lf_on ? cell_idx(lf_row, lf_col) : '0;
  assign st_idx  = st_on ? cell_idx({1'b0, start_row}, {1'b0, start_col}) : '0;
  assign cfg_idx = cfg_on ? cell_idx({1'b0, cfg_row}, {1'b0, cfg_col}) : '0;
  assign cur_v   = map_q[cur_idx];
  assign fr_v    = map_q[fr_idx];
  assign lf_v    = map_q[lf_idx];
  assign st_v    = map_q[st_idx];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:
        if (start) state_d = (!st_on || st_v == 3'd1 || st_v >= 3'd3) ? S_ANOMALY : S_SENSE;
      S_SENSE: state_d = S_ACT;
      S_ACT:
        if (act_go) begin
          state_d = S_SENSE;
          if (!(life_q != 4'd0 && recolher_entulho) && avancar &&
              (!fr_on || fr_v == 3'd1 || fr_v >= 3'd3)) state_d = S_ANOMALY;
        end
      default: state_d = S_ANOMALY;
    endcase
  end

  always_comb begin
    pos_row_d = pos_row_q; pos_col_d = pos_col_q; pos_dir_d = pos_dir_q; life_d = life_q;
    head_d = head_q; left_d = left_q; under_d = under_q; barrier_d = barrier_q;
    map_we = 1'b0; map_widx = '0; map_wdata = '0;
    sens_valid_d = (state_d == S_ACT);
    anomaly_d    = (state_d == S_ANOMALY);
    case (state_q)
      S_IDLE: begin
        if (cfg_we && cfg_on) begin map_we = 1'b1; map_widx = cfg_idx; map_wdata = cfg_cell; end
        if (start) begin pos_row_d = start_row; pos_col_d = start_col; pos_dir_d = start_dir; end
      end
      S_SENSE: begin
        head_d    = !fr_on || fr_v == 3'd1;
        left_d    = !lf_on || lf_v == 3'd1;
        under_d   = cur_on && cur_v == 3'd2;
        barrier_d = fr_on && fr_v >= 3'd3;
        if (barrier_d && life_q == 4'd0) life_d = life_of(fr_v);
      end
      S_ACT:
        if (act_go) begin
          if (life_q != 4'd0 && recolher_entulho) begin
            life_d = life_q - 4'd1;
            if (life_q == 4'd1 && fr_on) begin map_we = 1'b1; map_widx = fr_idx; map_wdata = 3'd0; end
          end else if (avancar) begin
            if (fr_on) begin pos_row_d = fr_row[ROW_W-1:0]; pos_col_d = fr_col[COL_W-1:0]; end
          end else if (girar) begin
            case (pos_dir_q)
              DIR_N:   pos_dir_d = DIR_O;
              DIR_O:   pos_dir_d = DIR_S;
              DIR_S:   pos_dir_d = DIR_L;
              default: pos_dir_d = DIR_N;
            endcase
          end
        end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pos_row_q <= '0; pos_col_q <= '0; pos_dir_q <= '0; life_q <= '0;
      head_q <= 1'b0; left_q <= 1'b0; under_q <= 1'b0; barrier_q <= 1'b0;
      sens_valid_q <= 1'b0; anomaly_q <= 1'b0;
    end else begin
      pos_row_q <= pos_row_d; pos_col_q <= pos_col_d; pos_dir_q <= pos_dir_d; life_q <= life_d;
      head_q <= head_d; left_q <= left_d; under_q <= under_d; barrier_q <= barrier_d;
      sens_valid_q <= sens_valid_d; anomaly_q <= anomaly_d;
    end
  end

  // Map contents survive reset.
  always_ff @(posedge clock) begin
    if (map_we) map_q[map_widx] <= map_wdata;
  end

  assign head = head_q;       assign left = left_q;
  assign under = under_q;     assign barrier = barrier_q;
  assign sens_valid = sens_valid_q;
  assign anomaly = anomaly_q;
  assign pos_row = pos_row_q; assign pos_col = pos_col_q;
  assign pos_dir = pos_dir_q; assign life_cnt = life_q;
endmodule

// File: tb/tb_robo_ambiente.sv
// Bench for robo_ambiente: directed scenarios plus random runs against a grid-level robot model.
module tb_robo_ambiente;
  localparam int ROWS = 10, COLS = 20, ROW_W = 4, COL_W = 5;

  logic clock = 1'b0, reset = 1'b0;
  logic cfg_we = 1'b0, start = 1'b0;
  logic [ROW_W-1:0] cfg_row = '0, start_row = '0;
  logic [COL_W-1:0] cfg_col = '0, start_col = '0;
  logic [2:0] cfg_cell = '0;
  logic [1:0] start_dir = '0;
  logic step_mode = 1'b0, step_req = 1'b0;
  logic avancar = 1'b0, girar = 1'b0, recolher_entulho = 1'b0;
  logic head, left, under, barrier, sens_valid, anomaly;
  logic [ROW_W-1:0] pos_row;
  logic [COL_W-1:0] pos_col;
  logic [1:0] pos_dir;
  logic [3:0] life_cnt;

  robo_ambiente #(.ROWS(ROWS), .COLS(COLS), .ROW_W(ROW_W), .COL_W(COL_W),
                  .LIFE_LEVE(3), .LIFE_MEDIO(6), .LIFE_PESADO(9)) dut (
    .clock(clock), .reset(reset), .cfg_we(cfg_we), .cfg_row(cfg_row), .cfg_col(cfg_col),
    .cfg_cell(cfg_cell), .start(start), .start_row(start_row), .start_col(start_col),
    .start_dir(start_dir),
`ifdef STEP_MODE_EN
    .step_mode(step_mode), .step_req(step_req),
`endif
    .avancar(avancar), .girar(girar), .recolher_entulho(recolher_entulho),
    .head(head), .left(left), .under(under), .barrier(barrier), .sens_valid(sens_valid),
    .pos_row(pos_row), .pos_col(pos_col), .pos_dir(pos_dir), .life_cnt(life_cnt),
    .anomaly(anomaly));

  always #5 clock = ~clock;

  int errors = 0, checks = 0;
  int m_map [ROWS][COLS];
  int m_r, m_c, m_d, m_life;
  bit m_anom;
  // Direction order N,S,L(east),O(west)
  int dr_f [4] = '{-1, 1, 0, 0};
  int dc_f [4] = '{0, 0, 1, -1};
  int dr_l [4] = '{0, 0, -1, 1};
  int dc_l [4] = '{-1, 1, 0, 0};
  int turn [4] = '{3, 2, 0, 1};

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic bit on_map(input int r, input int c);
    return r >= 0 && r < ROWS && c >= 0 && c < COLS;
  endfunction

  function automatic int life_for(input int code);
    return (code == 3) ? 3 : (code == 4) ? 6 : 9;
  endfunction

  task automatic check_pose(input string tag);
    check_val({tag, " row"}, int'(pos_row), m_r);
    check_val({tag, " col"}, int'(pos_col), m_c);
    check_val({tag, " dir"}, int'(pos_dir), m_d);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clock);
    reset = 1'b0; cfg_we = 0; start = 0; avancar = 0; girar = 0; recolher_entulho = 0; step_mode = 0;
    #1;
    check_val({tag, " async zero"},
              int'({head, left, under, barrier, sens_valid, anomaly, pos_row, pos_col, pos_dir, life_cnt}), 0);
    @(negedge clock);
    reset = 1'b1;
    m_life = 0; m_anom = 0;
    $display("reset %s", tag);
  endtask

  task automatic write_map();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        cfg_we = 1; cfg_row = ROW_W'(r); cfg_col = COL_W'(c); cfg_cell = 3'(m_map[r][c]);
        @(negedge clock);
      end
    cfg_we = 0;
  endtask

  task automatic begin_run(input int r, input int c, input int d, input string tag);
    start = 1; start_row = ROW_W'(r); start_col = COL_W'(c); start_dir = 2'(d);
    @(negedge clock);
    start = 0;
    m_r = r; m_c = c; m_d = d;
    m_anom = !on_map(r, c) || m_map[r][c] == 1 || m_map[r][c] >= 3;
    check_val({tag, " start anomaly"}, int'(anomaly), int'(m_anom));
    check_val({tag, " start sv"}, int'(sens_valid), 0);
    check_pose({tag, " start"});
    $display("start %s at (%0d,%0d,%0d) anomaly=%0d", tag, r, c, d, m_anom);
    if (!m_anom) @(negedge clock);
  endtask

  // Called at the negedge inside ACT; returns at the next ACT (or in ANOMALY).
  task automatic robot_step(input bit av, input bit gi, input bit re, input string tag);
    int fr, fc, lr, lc, h, l, u, b;
    fr = m_r + dr_f[m_d]; fc = m_c + dc_f[m_d];
    lr = m_r + dr_l[m_d]; lc = m_c + dc_l[m_d];
    h = !on_map(fr, fc) || m_map[fr][fc] == 1;
    l = !on_map(lr, lc) || m_map[lr][lc] == 1;
    u = m_map[m_r][m_c] == 2;
    b = on_map(fr, fc) && m_map[fr][fc] >= 3;
    if (b && m_life == 0) m_life = life_for(m_map[fr][fc]);
    check_val({tag, " sv act"}, int'(sens_valid), 1);
    check_val({tag, " head"}, int'(head), h);
    check_val({tag, " left"}, int'(left), l);
    check_val({tag, " under"}, int'(under), u);
    check_val({tag, " barrier"}, int'(barrier), b);
    check_val({tag, " life"}, int'(life_cnt), m_life);
    avancar = av; girar = gi; recolher_entulho = re;
    cfg_we = 1; cfg_row = ROW_W'($urandom_range(0, ROWS-1));
    cfg_col = COL_W'($urandom_range(0, COLS-1)); cfg_cell = 3'($urandom_range(0, 5));
    @(negedge clock);
    avancar = 0; girar = 0; recolher_entulho = 0; cfg_we = 0;
    if (m_life > 0 && re) begin
      m_life--;
      if (m_life == 0 && on_map(fr, fc)) m_map[fr][fc] = 0;
    end else if (av) begin
      if (!on_map(fr, fc)) m_anom = 1;
      else begin
        m_r = fr; m_c = fc;
        if (m_map[fr][fc] == 1 || m_map[fr][fc] >= 3) m_anom = 1;
      end
    end else if (gi) m_d = turn[m_d];
    check_val({tag, " anomaly"}, int'(anomaly), int'(m_anom));
    check_val({tag, " sv sense"}, int'(sens_valid), 0);
    check_pose(tag);
    $display("step %s cmd=%0d%0d%0d pos=(%0d,%0d,%0d) life=%0d anomaly=%0d",
             tag, av, gi, re, m_r, m_c, m_d, m_life, m_anom);
    if (!m_anom) @(negedge clock);
  endtask

  task automatic clear_map();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) m_map[r][c] = 0;
  endtask

  initial begin
    clear_map();
    m_r = 0; m_c = 0; m_d = 0; m_life = 0; m_anom = 0;
    do_reset("init");
    write_map();

    // Walk north to the edge and off it
    begin_run(2, 3, 0, "t1");
    robot_step(1, 0, 0, "t1a");
    robot_step(1, 0, 0, "t1b");
    robot_step(1, 0, 0, "t1c");
    repeat (3) @(negedge clock);
    check_val("t1 hold anomaly", int'(anomaly), 1);
    check_pose("t1 hold");

    do_reset("t2");
    begin_run(5, 5, 0, "t2");
    for (int i = 0; i < 4; i++) robot_step(0, 1, 0, "t2");

    do_reset("t3");
    m_map[1][3] = 4;
    write_map();
    begin_run(2, 3, 0, "t3");
    for (int i = 0; i < 6; i++) robot_step(0, 0, 1, "t3rm");
    robot_step(1, 0, 0, "t3mv");
    robot_step(0, 0, 0, "t3idle");

    do_reset("t4");
    m_map[1][3] = 1;
    write_map();
    begin_run(2, 3, 0, "t4");
    robot_step(1, 0, 0, "t4");
    start = 1; start_row = 4'd7; start_col = 5'd7; start_dir = 2'd2;
    @(negedge clock);
    start = 0;
    @(negedge clock);
    check_val("t4 start ignored", int'(anomaly), 1);
    check_pose("t4 start ignored");

    do_reset("t5");
    clear_map();
    m_map[4][19] = 2; m_map[6][6] = 3;
    write_map();
    begin_run(4, 19, 2, "t5edge");
    robot_step(0, 0, 0, "t5edge");
    do_reset("t5b");
    begin_run(6, 6, 0, "t5debris");
    do_reset("t5c");
    begin_run(12, 3, 0, "t5oob");

    // Reset mid-removal: map keeps the debris, life restarts
    do_reset("t6");
    m_map[1][3] = 4;
    write_map();
    begin_run(2, 3, 0, "t6");
    robot_step(0, 0, 1, "t6rm");
    robot_step(0, 0, 1, "t6rm");
    check_val("t6 life before reset", int'(life_cnt), 4);
    do_reset("t6mid");
    begin_run(2, 3, 0, "t6again");
    robot_step(0, 0, 0, "t6again");

`ifdef STEP_MODE_EN
    do_reset("tstep");
    clear_map();
    write_map();
    begin_run(5, 5, 0, "tstep");
    step_mode = 1; avancar = 1;
    repeat (4) begin
      @(negedge clock);
      check_val("tstep frozen row", int'(pos_row), 5);
      check_val("tstep held sv", int'(sens_valid), 1);
    end
    step_req = 1;
    @(negedge clock);
    step_req = 0; avancar = 0;
    check_val("tstep one row", int'(pos_row), 4);
    check_val("tstep sv", int'(sens_valid), 0);
    step_mode = 0;
`endif

    for (int run = 0; run < 12; run++) begin
      int sr, sc, k;
      do_reset("rand");
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) begin
          k = $urandom_range(0, 99);
          m_map[r][c] = (k < 70) ? 0 : (k < 80) ? 1 : (k < 88) ? 2 : (k < 92) ? 3 : (k < 96) ? 4 : 5;
        end
      sr = $urandom_range(0, ROWS-1); sc = $urandom_range(0, COLS-1);
      if (m_map[sr][sc] != 2) m_map[sr][sc] = 0;
      write_map();
      begin_run(sr, sc, $urandom_range(0, 3), "rand");
      for (int s = 0; s < 40 && !m_anom; s++)
        robot_step($urandom_range(0, 99) < 35, $urandom_range(0, 99) < 40,
                   $urandom_range(0, 99) < 50, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
